// File: rtl/cd_clkgen_pkg.sv
// Shared types and defaults for the derived clock / reset generator.
package cd_clkgen_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int unsigned CD_DIV_DEFAULT      = 1;
    localparam int unsigned CD_RST_HOLD_DEFAULT = 1;
    localparam int unsigned HOLD_CNT_W          = 8;

endpackage

// File: rtl/cd_clock_reset_gen_seq.sv
// Derived-domain reset sequencer: arms on a falling toggle, holds reset for
// RST_HOLD derived-clock falls, then reports ready.
module cd_reset_seq
    import cd_clkgen_pkg::*;
#(
    parameter int unsigned RST_HOLD = CD_RST_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic fall_i,
    input  logic run_i,
    input  logic sw_rst_i,
    output logic cd_reset_o,
    output logic ready_o
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

    seq_state_t              state_q;
    seq_state_t              state_d;
    logic [HOLD_CNT_W-1:0]   hold_q;
    logic [HOLD_CNT_W-1:0]   hold_d;
    logic                    cd_reset_q;
    logic                    cd_reset_d;
    logic                    ready_q;
    logic                    ready_d;
    logic                    edge_c;

    // Edges are only counted while the derived clock is running.
    assign edge_c = fall_i && run_i;

    // Next-state logic; a software request coincident with a fall arms on it.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cd_reset_d = cd_reset_q;
        if (sw_rst_i) begin
            if (edge_c) begin
                state_d    = HOLD;
                hold_d     = '0;
                cd_reset_d = 1'b1;
            end else begin
                state_d = ARM;
            end
        end else if (edge_c) begin
            case (state_q)
                ARM: begin
                    state_d    = HOLD;
                    hold_d     = '0;
                    cd_reset_d = 1'b1;
                end
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d    = RUN;
                        hold_d     = '0;
                        cd_reset_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HOLD_CNT_W'(1);
                    end
                end
                RUN: begin
                    cd_reset_d = 1'b0;
                end
                default: begin
                    state_d    = ARM;
                    hold_d     = '0;
                end
            endcase
        end
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARM;
            hold_q     <= '0;
            cd_reset_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cd_reset_q <= cd_reset_d;
            ready_q    <= ready_d;
        end
    end

    assign cd_reset_o = cd_reset_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/cd_clock_reset_gen.sv
// Glitch-free programmable clock divider with an attached derived-domain
// reset sequencer; everything runs on clk.
module cd_clock_reset_gen
    import cd_clkgen_pkg::*;
#(
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned DIV_DEFAULT = CD_DIV_DEFAULT,
    parameter int unsigned RST_HOLD    = CD_RST_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             sw_rst_i,
    output logic             cd_clk_o,
    output logic             cd_reset_o,
    output logic             cd_rise_o,
    output logic             cd_fall_o,
    output logic             ready_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             cd_clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             stop_c;
    logic             hit_c;
    logic             toggle_c;
    logic             fall_tog_c;

    // Stopping is only allowed at the start of a low phase, so no short pulses.
    assign stop_c     = !en_i && !cd_clk_q && (cnt_q == '0);
    assign hit_c      = (cnt_q == div_q);
    assign toggle_c   = !stop_c && hit_c;
    assign fall_tog_c = toggle_c && cd_clk_q;

    // Divider; a new divisor is adopted only at a period boundary or while stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(DIV_DEFAULT);
            cd_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= toggle_c && !cd_clk_q;
            fall_q <= fall_tog_c;
            if (stop_c) begin
                cnt_q <= '0;
                div_q <= div_i;
            end else if (hit_c) begin
                cnt_q    <= '0;
                cd_clk_q <= !cd_clk_q;
                if (cd_clk_q) begin
                    div_q <= div_i;
                end
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

    cd_reset_seq #(
        .RST_HOLD (RST_HOLD)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .fall_i     (fall_tog_c),
        .run_i      (!stop_c),
        .sw_rst_i   (sw_rst_i),
        .cd_reset_o (cd_reset_o),
        .ready_o    (ready_o)
    );

    assign cd_clk_o  = cd_clk_q;
    assign cd_rise_o = rise_q;
    assign cd_fall_o = fall_q;

endmodule

// File: tb/tb_cd_clock_reset_gen.sv
// Directed bench for cd_clock_reset_gen: derived-clock edges are scoreboarded
// by cycle number, reset/ready checked at fixed cycles.
module tb_cd_clock_reset_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] div;
    logic       sw;
    logic       sw3;

    logic cd_clk, cd_reset, cd_rise, cd_fall, ready;
    logic cd_clk3, cd_reset3, cd_rise3, cd_fall3, ready3;

    int cyc;
    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    logic prev_clk = 1'b0;

    cd_clock_reset_gen u_dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .div_i      (div),
        .sw_rst_i   (sw),
        .cd_clk_o   (cd_clk),
        .cd_reset_o (cd_reset),
        .cd_rise_o  (cd_rise),
        .cd_fall_o  (cd_fall),
        .ready_o    (ready)
    );

    cd_clock_reset_gen #(
        .RST_HOLD (3)
    ) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .div_i      (div),
        .sw_rst_i   (sw3),
        .cd_clk_o   (cd_clk3),
        .cd_reset_o (cd_reset3),
        .cd_rise_o  (cd_rise3),
        .cd_fall_o  (cd_fall3),
        .ready_o    (ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Expected edge code: cycle*2 + 1 for a fall, + 0 for a rise.
    task automatic push_ev(input int c, input bit f);
        exp_q.push_back(c * 2 + int'(f));
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_seq(input string tag, input logic r, input logic rd, input logic r3, input logic rd3);
        chk({tag, "_reset"}, 32'(r), 32'(rd));
        chk({tag, "_ready"}, 32'(r3), 32'(rd3));
    endtask

    // Edge monitor: pulses must track cd_clk transitions and match the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_clk = 1'b0;
        end else begin
            chk("rise_vs_clk", 32'(cd_rise), 32'(cd_clk && !prev_clk));
            chk("fall_vs_clk", 32'(cd_fall), 32'(!cd_clk && prev_clk));
            if (cd_rise || cd_fall) begin
                if (exp_q.size() == 0)
                    chk("unexpected_edge", 32'(cyc * 2 + int'(cd_fall)), 32'hffff_ffff);
                else
                    chk("edge_time", 32'(cyc * 2 + int'(cd_fall)), 32'(exp_q.pop_front()));
            end
            prev_clk = cd_clk;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; div = 4'd1; sw = 1'b0; sw3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk", 32'(cd_clk), 32'd0);
        chk("rst_outs", 32'({cd_reset, cd_rise, cd_fall, ready}), 32'd0);
        chk("rst_outs3", 32'({cd_clk3, cd_reset3, cd_rise3, cd_fall3, ready3}), 32'd0);
        rst = 1'b0;

        // Defaults: period 4, reset pulse from first to second fall.
        push_ev(2, 0); push_ev(4, 1); push_ev(6, 0); push_ev(8, 1); push_ev(10, 0); push_ev(12, 1);
        at(3);  chk_seq("c3",  cd_reset, 1'b0, ready, 1'b0);
        at(4);  chk_seq("c4",  cd_reset, 1'b1, ready, 1'b0);
                chk("c4_reset3", 32'(cd_reset3), 32'd1);
        at(7);  chk_seq("c7",  cd_reset, 1'b1, ready, 1'b0);
        at(8);  chk_seq("c8",  cd_reset, 1'b0, ready, 1'b1);

        // Divisor change mid high phase takes effect after the current period.
        at(10); div = 4'd3;
        push_ev(16, 0); push_ev(20, 1); push_ev(24, 0); push_ev(28, 1); push_ev(32, 0); push_ev(36, 1);
        push_ev(40, 0); push_ev(44, 1); push_ev(48, 0); push_ev(52, 1); push_ev(56, 0); push_ev(60, 1);
        at(15); chk_seq("d3_c15", cd_reset3, 1'b1, ready3, 1'b0);
        at(19); chk_seq("d3_c19", cd_reset3, 1'b1, ready3, 1'b0);
        at(20); chk_seq("d3_c20", cd_reset3, 1'b0, ready3, 1'b1);

        // Software reset in RUN with RST_HOLD=3.
        at(22); chk("d3_c22_ready", 32'(ready3), 32'd1);
        sw3 = 1'b1;
        at(23); sw3 = 1'b0;
        chk_seq("d3_c23", cd_reset3, 1'b0, ready3, 1'b0);
        at(27); chk_seq("d3_c27", cd_reset3, 1'b0, ready3, 1'b0);
        at(28); chk_seq("d3_c28", cd_reset3, 1'b1, ready3, 1'b0);

        // Software reset coincident with a falling toggle arms on that toggle.
        at(35); chk_seq("c35", cd_reset, 1'b0, ready, 1'b1);
        sw = 1'b1;
        at(36); sw = 1'b0;
        chk_seq("c36", cd_reset, 1'b1, ready, 1'b0);
        at(43); chk_seq("c43", cd_reset, 1'b1, ready, 1'b0);
        at(44); chk_seq("c44", cd_reset, 1'b0, ready, 1'b1);
        at(51); chk_seq("d3_c51", cd_reset3, 1'b1, ready3, 1'b0);
        at(52); chk_seq("d3_c52", cd_reset3, 1'b0, ready3, 1'b1);

        // Enable dropped in high phase: finish the period, then stay low.
        at(57); en = 1'b0;
        at(65); chk("stop_c65_clk", 32'(cd_clk), 32'd0);
        at(70); chk("stop_c70_clk", 32'(cd_clk), 32'd0);
        chk_seq("stop_c70", cd_reset, 1'b0, ready, 1'b1);
        en = 1'b1;
        push_ev(74, 0); push_ev(78, 1); push_ev(82, 0); push_ev(86, 1);

        // Minimum divisor, then maximum divisor.
        at(80); div = 4'd0;
        for (int c = 87; c <= 96; c++) push_ev(c, (c % 2) == 0);
        at(95); div = 4'd15;
        push_ev(112, 0); push_ev(128, 1); push_ev(144, 0); push_ev(160, 1);
        at(150); div = 4'd1;
        push_ev(162, 0); push_ev(164, 1); push_ev(166, 0);

        // Async reset while in HOLD, during a high phase.
        at(161); sw = 1'b1;
        at(162); sw = 1'b0;
        chk_seq("c162", cd_reset, 1'b0, ready, 1'b0);
        at(164); chk_seq("c164", cd_reset, 1'b1, ready, 1'b0);
        at(166); chk("c166_clk", 32'(cd_clk), 32'd1);
        #2 rst = 1'b1;
        div = 4'd2;
        #1;
        chk("async_rst_outs", 32'({cd_clk, cd_reset, cd_rise, cd_fall, ready}), 32'd0);
        chk("async_rst_outs3", 32'({cd_clk3, cd_reset3, cd_rise3, cd_fall3, ready3}), 32'd0);
        chk("edges_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Restart: reset divisor applies to the first period, then div_i.
        push_ev(2, 0); push_ev(4, 1); push_ev(7, 0); push_ev(10, 1);
        at(3);  chk_seq("r3",  cd_reset, 1'b0, ready, 1'b0);
        at(4);  chk_seq("r4",  cd_reset, 1'b1, ready, 1'b0);
        at(9);  chk_seq("r9",  cd_reset, 1'b1, ready, 1'b0);
        at(10); chk_seq("r10", cd_reset, 1'b0, ready, 1'b1);
        at(11); chk("edges_drained_end", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cd_clock_reset_gen.md
CD_CLOCK_RESET_GEN -- requirements
Module: cd_clock_reset_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 4: width of divisor input and half-period counter.
REQ-002 SHALL have parameter DIV_DEFAULT, default 1: divisor loaded at reset (half-period 2, i.e. clk/4).
REQ-003 SHALL have parameter RST_HOLD, default 1: number of cd_clk falling edges cd_reset_o stays high, range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_i  input  1  derived clock run enable.
REQ-007 SHALL have port div_i  input  DIV_W  requested divisor; half-period = div_i+1 clk cycles.
REQ-008 SHALL have port sw_rst_i  input  1  one-cycle request to re-run the derived-domain reset sequence.
REQ-009 SHALL have port cd_clk_o  output  1  derived clock, registered.
REQ-010 SHALL have port cd_reset_o  output  1  derived-domain synchronous reset, active-high, registered.
REQ-011 SHALL have port cd_rise_o  output  1  high in the cycle cd_clk_o first reads 1.
REQ-012 SHALL have port cd_fall_o  output  1  high in the cycle cd_clk_o first reads 0.
REQ-013 SHALL have port ready_o  output  1  high when reset sequence complete and no request pending.

Function
REQ-014 Divider SHALL keep counter cnt (DIV_W bits) and active divisor div_q; toggle cd_clk_o and clear cnt when cnt==div_q, else increment cnt.
REQ-015 Period SHALL be 2*(div_q+1) clk cycles, duty 50%; div_q=0 gives clk/2, div_q=2^DIV_W-1 gives maximum.
REQ-016 div_q SHALL load div_i only on a falling toggle (1->0) or while stopped; changes mid-period SHALL NOT shorten or stretch the current period (glitch-free).
REQ-017 en_i low SHALL stop cd_clk_o low at the next falling toggle (immediately if already low at a period start) with cnt held 0; en_i high SHALL resume with first rise after div_q+1 cycles.
REQ-018 cd_rise_o/cd_fall_o SHALL be single-cycle pulses, never both high, never while stopped.
REQ-019 Reset sequencer SHALL have states ARM, HOLD, RUN.
REQ-020 ARM: cd_reset_o unchanged; on falling toggle -> HOLD, cd_reset_o=1, hold_cnt=0.
REQ-021 HOLD: each falling toggle increments hold_cnt; on the RST_HOLD-th falling toggle after entry -> RUN, cd_reset_o=0.
REQ-022 RUN: ready_o=1, cd_reset_o=0.
REQ-023 sw_rst_i in any state SHALL go to ARM next cycle and drop ready_o; in HOLD cd_reset_o stays 1.
REQ-024 sw_rst_i coincident with a falling toggle SHALL treat that toggle as the arming edge (-> HOLD, hold_cnt=0).
REQ-025 cd_reset_o SHALL change only on falling toggles, so it is stable across every cd_clk_o rising edge.
REQ-026 While stopped (en_i low) the sequencer SHALL hold state; no edges are counted.

Reset
REQ-027 On rst: cd_clk_o=0, cd_reset_o=0, cd_rise_o=0, cd_fall_o=0, ready_o=0, cnt=0, hold_cnt=0, div_q=DIV_DEFAULT, state=ARM.
REQ-028 rst low 0 cd_reset_o guarantees an observable rising edge of cd_reset_o after the derived clock has run at least one full period.
REQ-029 rst asserted mid-operation SHALL force REQ-027 values immediately regardless of clock phase.

Structure
REQ-030 Sequencer state encoding, DIV_DEFAULT and RST_HOLD defaults SHALL live in shared package cd_clkgen_pkg.
REQ-031 Sequencer SHALL be sub-module cd_reset_seq, driven by falling-toggle strobe, sw_rst_i, and run flag.

Verification
REQ-032 Defaults, en_i=1, release rst -> cd_clk_o period 4 clk; cd_reset_o rises at 1st fall (clk cycle 4), falls at 2nd fall (cycle 8), ready_o=1 from cycle 8.
REQ-033 div_i 1->3 written mid-high-phase -> current period stays 4, following periods 8, no short pulse.
REQ-034 RST_HOLD=3, sw_rst_i pulse in RUN -> ready_o 0 next cycle; cd_reset_o high for exactly 3 cd_clk periods.
REQ-035 en_i low during high phase -> cd_clk_o falls on schedule then stays low, no rise/fall pulses; en_i high -> first rise after div_q+1 cycles.
REQ-036 div_i=0 -> clk/2; div_i=15 (DIV_W=4) -> period 32; cd_rise_o count equals cd_clk_o rising edges.
REQ-037 rst asserted during HOLD -> all outputs 0 same cycle, sequence restarts from ARM after release.
